// File: rtl/dcp_pkg.sv
// Shared definitions for the debug-command processor print path:
// formatter state encodings, request type codes and nibble-to-ASCII helper.
package dcp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_REL  = 2'd3
    } dcp_state_e;

    localparam logic TYPE_CHAR = 1'b0;
    localparam logic TYPE_WORD = 1'b1;

    // Digits 0-9 map to '0'..'9'; 10-15 map to 'A'..'F' or 'a'..'f'.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nibble, input logic upper);
        logic [7:0] n8;
        n8 = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return 8'h30 + n8;
        end else begin
            return (upper ? 8'h41 : 8'h61) + n8 - 8'd10;
        end
    endfunction

endpackage

// File: rtl/dcp_tx_formatter.sv
// Print stage between the DCP command FSM and the UART transmitter.
// Turns a char or word print request into a stream of ASCII bytes over a
// valid/ready byte interface and acknowledges completion with a 1-cycle pulse.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for req_tx; latches type/data on acceptance
//  ST_SEND  | presenting bytes, one per vld_tx&rdy_tx transfer
//  ST_DONE  | ack_tx high for this single cycle
//  ST_REL   | waiting for the requester to drop req_tx
module dcp_tx_formatter
    import dcp_pkg::*;
#(
    parameter int unsigned HEX_DIGITS = 8,
    parameter bit          UPPER_HEX  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] dout_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    // Word prints are left-aligned into the shadow so the next digit is
    // always shadow[31:28]; with fewer digits the unprinted high bits fall off.
    localparam int unsigned ALIGN    = 4 * (8 - HEX_DIGITS);
    localparam logic [3:0]  WORD_CNT = 4'(HEX_DIGITS);

    dcp_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d;
    logic        ack_q, ack_d;

    logic [31:0] aligned;
    logic [31:0] shifted;
    logic        xfer;

    assign aligned = dout_tx << ALIGN;
    assign shifted = {shadow_q[27:0], 4'h0};
    assign xfer    = vld_q & rdy_tx;

    // State, counter, shadow and registered outputs; cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            shadow_q <= 32'h0;
            data_q   <= 8'h00;
            vld_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state logic; the byte for the next digit is precomputed so it
    // appears on d_tx the cycle after each transfer (1 byte/clk sustained).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        vld_d    = vld_q;
        ack_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_tx) begin
                    if (type_tx == TYPE_WORD) begin
                        shadow_d = aligned;
                        cnt_d    = WORD_CNT;
                        data_d   = nib2ascii(aligned[31:28], UPPER_HEX);
                    end else begin
                        shadow_d = dout_tx;
                        cnt_d    = 4'd1;
                        data_d   = dout_tx[7:0];
                    end
                    vld_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    if (cnt_q == 4'd1) begin
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        shadow_d = shifted;
                        data_d   = nib2ascii(shifted[31:28], UPPER_HEX);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_REL;
            end

            ST_REL: begin
                // A level request left high after ack must not start a new print.
                if (!req_tx) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    assign ack_tx = ack_q;
    assign d_tx   = data_q;
    assign vld_tx = vld_q;

endmodule
